delay_sweep_scheduler: RTL

- Autonomous sweep sequencer for the trigger delay datapath.
- Steps the coarse delay (cycles) and the fine delay (ps) across a configured 2-D grid, with fine as the inner loop and coarse as the outer loop.
- Holds each grid point until a configured number of trigger events has been observed, then advances.
- Sits between the UART command FSM (configuration, start/abort) and the delay core's coarse_delay/coarse_update/fine_delay_ps/fine_update inputs. It also takes the counter edge pulse and mmcm_locked back from the core.

---
 rtl/delay_sweep_scheduler_if.sv | 37 +++
 rtl/delay_sweep_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_sweep_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : delay_sweep_scheduler_if
// Purpose  : Scheduler <-> delay core bus (delay values, load strobes, feedback)
// Revision : 1.0 - initial release
// ============================================================================
interface delay_sweep_scheduler_if #(
  parameter int COARSE_W = 32,
  parameter int FINE_W   = 16
);
  logic [COARSE_W-1:0] coarse_delay;
  logic                coarse_update;
  logic [FINE_W-1:0]   fine_delay_ps;
  logic                fine_update;
  logic                trigger_pulse;
  logic                mmcm_locked;

  modport master (
    output coarse_delay,
    output coarse_update,
    output fine_delay_ps,
    output fine_update,
    input  trigger_pulse,
    input  mmcm_locked
  );

  modport slave (
    input  coarse_delay,
    input  coarse_update,
    input  fine_delay_ps,
    input  fine_update,
    output trigger_pulse,
    output mmcm_locked
  );
endinterface
`default_nettype wire

// File: rtl/delay_sweep_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : delay_sweep_scheduler
// Purpose  : 2-D coarse/fine delay sweep, fine inner loop, N triggers per point
// Revision : 1.0 - initial release
// ============================================================================
module delay_sweep_scheduler #(
  parameter int COARSE_W      = 32,
  parameter int FINE_W        = 16,
  parameter int SHOT_W        = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                start,
  input  wire logic                abort,
  input  wire logic [COARSE_W-1:0] cfg_coarse_start,
  input  wire logic [COARSE_W-1:0] cfg_coarse_stop,
  input  wire logic [COARSE_W-1:0] cfg_coarse_step,
  input  wire logic [FINE_W-1:0]   cfg_fine_start,
  input  wire logic [FINE_W-1:0]   cfg_fine_stop,
  input  wire logic [FINE_W-1:0]   cfg_fine_step,
  input  wire logic [SHOT_W-1:0]   cfg_shots,
  delay_sweep_scheduler_if.master  dly,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              point_index,
  output logic [SHOT_W-1:0]        shot_count
);

  localparam int c_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_ARMED     = 3'd4,
    ST_ADVANCE   = 3'd5
  } state_t;

  state_t r_state;

  // Shadow copy of the grid, frozen at start so cfg_* may change mid-sweep.
  logic [COARSE_W-1:0] r_cfg_coarse_start;
  logic [COARSE_W-1:0] r_cfg_coarse_stop;
  logic [COARSE_W-1:0] r_cfg_coarse_step;
  logic [FINE_W-1:0]   r_cfg_fine_start;
  logic [FINE_W-1:0]   r_cfg_fine_stop;
  logic [FINE_W-1:0]   r_cfg_fine_step;
  logic [SHOT_W-1:0]   r_cfg_shots;

  logic [COARSE_W-1:0]   r_cur_coarse;
  logic [FINE_W-1:0]     r_cur_fine;
  logic [c_SETTLE_W-1:0] r_settle;

  logic [COARSE_W-1:0] r_coarse_delay;
  logic [FINE_W-1:0]   r_fine_delay_ps;
  logic                r_coarse_update;
  logic                r_fine_update;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_point_index;
  logic [SHOT_W-1:0]   r_shot_count;

  logic [SHOT_W-1:0]   w_shot_target;
  logic [SHOT_W-1:0]   w_shot_inc;
  logic [FINE_W:0]     w_next_fine;
  logic [COARSE_W:0]   w_next_coarse;
  logic                w_fine_adv;
  logic                w_coarse_adv;

  assign w_shot_target = (r_cfg_shots == '0) ? SHOT_W'(1) : r_cfg_shots;
  assign w_shot_inc    = r_shot_count + 1'b1;

  // One extra bit catches wrap-around so an overflowing step ends the axis.
  assign w_next_fine   = {1'b0, r_cur_fine} + {1'b0, r_cfg_fine_step};
  assign w_next_coarse = {1'b0, r_cur_coarse} + {1'b0, r_cfg_coarse_step};

  assign w_fine_adv   = (r_cfg_fine_step != '0) && !w_next_fine[FINE_W] &&
                        (w_next_fine[FINE_W-1:0] <= r_cfg_fine_stop);
  assign w_coarse_adv = (r_cfg_coarse_step != '0) && !w_next_coarse[COARSE_W] &&
                        (w_next_coarse[COARSE_W-1:0] <= r_cfg_coarse_stop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_cfg_coarse_start <= '0;
      r_cfg_coarse_stop  <= '0;
      r_cfg_coarse_step  <= '0;
      r_cfg_fine_start   <= '0;
      r_cfg_fine_stop    <= '0;
      r_cfg_fine_step    <= '0;
      r_cfg_shots        <= '0;
      r_cur_coarse       <= '0;
      r_cur_fine         <= '0;
      r_settle           <= '0;
      r_coarse_delay     <= '0;
      r_fine_delay_ps    <= '0;
      r_coarse_update    <= 1'b0;
      r_fine_update      <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_point_index      <= '0;
      r_shot_count       <= '0;
    end else begin
      r_coarse_update <= 1'b0;
      r_fine_update   <= 1'b0;
      r_done          <= 1'b0;

      // Abort outranks everything else that could happen in the same cycle.
      if ((r_state != ST_IDLE) && abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_cfg_coarse_start <= cfg_coarse_start;
              r_cfg_coarse_stop  <= cfg_coarse_stop;
              r_cfg_coarse_step  <= cfg_coarse_step;
              r_cfg_fine_start   <= cfg_fine_start;
              r_cfg_fine_stop    <= cfg_fine_stop;
              r_cfg_fine_step    <= cfg_fine_step;
              r_cfg_shots        <= cfg_shots;
              r_cur_coarse       <= cfg_coarse_start;
              r_cur_fine         <= cfg_fine_start;
              r_point_index      <= '0;
              r_busy             <= 1'b1;
              r_state            <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            r_coarse_delay  <= r_cur_coarse;
            r_fine_delay_ps <= r_cur_fine;
            r_coarse_update <= 1'b1;
            r_fine_update   <= 1'b1;
            r_shot_count    <= '0;
            r_settle        <= '0;
            r_state         <= ST_SETTLE;
          end

          ST_SETTLE: begin
            if (r_settle == c_SETTLE_LAST) begin
              r_state <= ST_WAIT_LOCK;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end

          ST_WAIT_LOCK: begin
            if (dly.mmcm_locked) begin
              r_state <= ST_ARMED;
            end
          end

          ST_ARMED: begin
            if (dly.trigger_pulse && dly.mmcm_locked) begin
              r_shot_count <= w_shot_inc;
              if (w_shot_inc >= w_shot_target) begin
                r_state <= ST_ADVANCE;
              end
            end
          end

          ST_ADVANCE: begin
            if (w_fine_adv) begin
              r_cur_fine    <= w_next_fine[FINE_W-1:0];
              r_point_index <= r_point_index + 32'd1;
              r_state       <= ST_LOAD;
            end else begin
              r_cur_fine <= r_cfg_fine_start;
              if (w_coarse_adv) begin
                r_cur_coarse  <= w_next_coarse[COARSE_W-1:0];
                r_point_index <= r_point_index + 32'd1;
                r_state       <= ST_LOAD;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end

          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign dly.coarse_delay  = r_coarse_delay;
  assign dly.coarse_update = r_coarse_update;
  assign dly.fine_delay_ps = r_fine_delay_ps;
  assign dly.fine_update   = r_fine_update;
  assign busy              = r_busy;
  assign done              = r_done;
  assign point_index       = r_point_index;
  assign shot_count        = r_shot_count;

endmodule
`default_nettype wire
